booth_mul_sched: RTL

//  Shares one sequential 4x4 signed Booth multiplier core among NREQ requesters.

---
 rtl/booth_mul_sched.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/booth_mul_sched.sv
// Round-robin scheduler sharing one sequential Booth multiplier core.
// Optional WAIT watchdog: define BOOTH_SCHED_TIMEOUT_EN.
module booth_mul_sched #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic                    mul_start,
  output logic [WIDTH-1:0]        mul_in1,
  output logic [WIDTH-1:0]        mul_in2,
  input  logic                    mul_done,
  input  logic [2*WIDTH-1:0]      mul_out,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [2*WIDTH-1:0]      rsp_prod,
  output logic                    rsp_err
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  if (NREQ < 2 || TIMEOUT < 1) begin : g_bad_cfg
  end

  state_t               state_q, state_d;
  logic [ID_W-1:0]      rr_q, rr_d;
  logic [ID_W-1:0]      gid_q, gid_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic                 vld_q, vld_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic                 err_q, err_d;

  logic                 found;
  logic [ID_W-1:0]      gnt;
  logic [ID_W-1:0]      idx;
  logic [NREQ-1:0]      one;

`ifdef BOOTH_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]        wcnt_q, wcnt_d;
`endif

  assign one = {{(NREQ-1){1'b0}}, 1'b1};

  // first valid requester scanning upward from rr_q, wrapping
  always_comb begin
    found = 1'b0;
    gnt   = rr_q;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = rr_q + ID_W'(k);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
  end

  assign req_ready =
    (state_q == IDLE && found) ? (one << gnt) : '0;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gid_d   = gid_q;
    a_d     = a_q;
    b_d     = b_q;
    vld_d   = vld_q;
    id_d    = id_q;
    prod_d  = prod_q;
    err_d   = err_q;
`ifdef BOOTH_SCHED_TIMEOUT_EN
    wcnt_d  = wcnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (found) begin
          gid_d   = gnt;
          a_d     = req_a[gnt*WIDTH +: WIDTH];
          b_d     = req_b[gnt*WIDTH +: WIDTH];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef BOOTH_SCHED_TIMEOUT_EN
        wcnt_d  = '0;
`endif
      end
      WAIT: begin
        if (mul_done) begin
          prod_d  = mul_out;
          id_d    = gid_q;
          vld_d   = 1'b1;
          err_d   = 1'b0;
          state_d = RESP;
        end
`ifdef BOOTH_SCHED_TIMEOUT_EN
        else if (wcnt_q == TW'(TIMEOUT - 1)) begin
          prod_d  = '0;
          id_d    = gid_q;
          vld_d   = 1'b1;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          wcnt_d  = wcnt_q + TW'(1);
        end
`endif
      end
      RESP: begin
        if (rsp_ready) begin
          vld_d   = 1'b0;
          err_d   = 1'b0;
          rr_d    = gid_q + ID_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      gid_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      vld_q   <= 1'b0;
      id_q    <= '0;
      prod_q  <= '0;
      err_q   <= 1'b0;
`ifdef BOOTH_SCHED_TIMEOUT_EN
      wcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gid_q   <= gid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      vld_q   <= vld_d;
      id_q    <= id_d;
      prod_q  <= prod_d;
      err_q   <= err_d;
`ifdef BOOTH_SCHED_TIMEOUT_EN
      wcnt_q  <= wcnt_d;
`endif
    end
  end

  assign mul_start = (state_q == ISSUE);
  assign mul_in1   = a_q;
  assign mul_in2   = b_q;
  assign rsp_valid = vld_q;
  assign rsp_id    = id_q;
  assign rsp_prod  = prod_q;
`ifdef BOOTH_SCHED_TIMEOUT_EN
  assign rsp_err   = err_q;
`else
  assign rsp_err   = 1'b0;
  logic unused_err;
  assign unused_err = err_q;
`endif

endmodule
